// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register address
// width, FSM state encodings and the bundle of per-cycle pipeline controls.
package pipeline_hazard_ctrl_pkg;

  localparam int ASIZE = 5;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd2;

  typedef struct packed {
    logic pcStall;
    logic ifidStall;
    logic idexBubble;
    logic ifidFlush;
    logic idexFlush;
    logic idexStall;
    logic exmemStall;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave): ID/EXE/MEM hazard sources in, stall/flush controls out.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic [ASIZE-1:0] id_rs;
  logic [ASIZE-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memRead;
  logic             ex_wen;
  logic [ASIZE-1:0] ex_waddr;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             idex_stall;
  logic             exmem_stall;
  logic             mem_timeout;
  logic [15:0]      stall_cnt;
  logic [1:0]       state;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memRead, ex_wen, ex_waddr,
           ex_redirect, mem_req, mem_ready,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
           idex_stall, exmem_stall, mem_timeout, stall_cnt, state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memRead, ex_wen, ex_waddr,
           ex_redirect, mem_req, mem_ready,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
           idex_stall, exmem_stall, mem_timeout, stall_cnt, state
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load in EXE is about to write. Register 0 never creates a hazard.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             i_exMemRead,
  input  logic             i_exWen,
  input  logic [ASIZE-1:0] i_exWaddr,
  input  logic [ASIZE-1:0] i_idRs,
  input  logic [ASIZE-1:0] i_idRt,
  input  logic             i_idUsesRt,
  output logic             o_hazard
);

  logic w_rsMatch;
  logic w_rtMatch;

  assign w_rsMatch = (i_exWaddr == i_idRs);
  assign w_rtMatch = i_idUsesRt & (i_exWaddr == i_idRt);
  assign o_hazard  = i_exMemRead & i_exWen & (i_exWaddr != '0) & (w_rsMatch | w_rtMatch);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, wrong-path squash on
// redirects, full freeze while data memory is busy (with a sticky timeout
// flag), and a saturating count of PC-stall cycles.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);
  import pipeline_hazard_ctrl_pkg::*;

  localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);
  localparam logic [2:0]  LSC_M1      = 3'(LOAD_STALL_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_retState;
  logic [2:0]  r_lcnt;
  logic [15:0] r_wcnt;
  logic [15:0] r_stallCnt;
  logic        r_memTimeout;

  logic        w_hazard;
  logic        w_memWait;
  logic        w_inMemWait;
  logic        w_fullStall;
  logic [1:0]  w_baseState;
  logic [1:0]  w_evalState;
  logic [15:0] w_wcntInc;
  ctrl_t       w_ctrl;
  ctrl_t       w_outCtrl;
  logic [1:0]  w_nextState;
  logic [1:0]  w_nextRet;
  logic [2:0]  w_nextLcnt;
  logic [15:0] w_nextWcnt;
  logic        w_setTimeout;

  load_use_detect u_detect (
    .i_exMemRead (bus.ex_memRead),
    .i_exWen     (bus.ex_wen),
    .i_exWaddr   (bus.ex_waddr),
    .i_idRs      (bus.id_rs),
    .i_idRt      (bus.id_rt),
    .i_idUsesRt  (bus.id_uses_rt),
    .o_hazard    (w_hazard)
  );

  assign w_memWait   = bus.mem_req & ~bus.mem_ready;
  assign w_inMemWait = (r_state == ST_MEM_WAIT);
  // The unused encoding 3 behaves exactly like RUN.
  assign w_baseState = (r_state == ST_LOAD_STALL) ? ST_LOAD_STALL : ST_RUN;
  // On memory completion the cycle is judged as the state we were frozen in.
  assign w_evalState = w_inMemWait ? r_retState : w_baseState;
  assign w_fullStall = w_inMemWait ? ~bus.mem_ready : w_memWait;
  assign w_wcntInc   = (r_wcnt >= TIMEOUT_VAL) ? r_wcnt : r_wcnt + 16'd1;

  // Decide this cycle's pipeline controls and the next FSM/counter values.
  always_comb begin
    w_ctrl       = CTRL_NONE;
    w_nextState  = ST_RUN;
    w_nextRet    = r_retState;
    w_nextLcnt   = r_lcnt;
    w_nextWcnt   = r_wcnt;
    w_setTimeout = 1'b0;
    if (w_fullStall) begin
      w_ctrl.pcStall    = 1'b1;
      w_ctrl.ifidStall  = 1'b1;
      w_ctrl.idexStall  = 1'b1;
      w_ctrl.exmemStall = 1'b1;
      w_nextState       = ST_MEM_WAIT;
      w_nextWcnt        = w_wcntInc;
      w_setTimeout      = (w_wcntInc == TIMEOUT_VAL);
      if (!w_inMemWait) begin
        w_nextRet = w_evalState;
      end
    end else begin
      if (w_inMemWait) begin
        w_nextWcnt = '0;
      end
      if (w_evalState == ST_LOAD_STALL) begin
        w_ctrl.pcStall    = 1'b1;
        w_ctrl.ifidStall  = 1'b1;
        w_ctrl.idexBubble = 1'b1;
        w_nextLcnt        = r_lcnt - 3'd1;
        w_nextState       = (r_lcnt <= 3'd1) ? ST_RUN : ST_LOAD_STALL;
      end else if (bus.ex_redirect) begin
        w_ctrl.ifidFlush = 1'b1;
        w_ctrl.idexFlush = 1'b1;
      end else if (w_hazard) begin
        w_ctrl.pcStall    = 1'b1;
        w_ctrl.ifidStall  = 1'b1;
        w_ctrl.idexBubble = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          w_nextLcnt  = LSC_M1;
          w_nextState = ST_LOAD_STALL;
        end
      end
    end
  end

  assign w_outCtrl = rst ? CTRL_NONE : w_ctrl;

  assign bus.pc_stall    = w_outCtrl.pcStall;
  assign bus.ifid_stall  = w_outCtrl.ifidStall;
  assign bus.idex_bubble = w_outCtrl.idexBubble;
  assign bus.ifid_flush  = w_outCtrl.ifidFlush;
  assign bus.idex_flush  = w_outCtrl.idexFlush;
  assign bus.idex_stall  = w_outCtrl.idexStall;
  assign bus.exmem_stall = w_outCtrl.exmemStall;
  assign bus.mem_timeout = r_memTimeout;
  assign bus.stall_cnt   = r_stallCnt;
  assign bus.state       = r_state;

  // Commit FSM state, counters and the sticky timeout; reset abandons any stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_retState   <= ST_RUN;
      r_lcnt       <= '0;
      r_wcnt       <= '0;
      r_stallCnt   <= '0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_retState   <= w_nextRet;
      r_lcnt       <= w_nextLcnt;
      r_wcnt       <= w_nextWcnt;
      r_memTimeout <= r_memTimeout | w_setTimeout;
      if (w_ctrl.pcStall && (r_stallCnt != 16'hFFFF)) begin
        r_stallCnt <= r_stallCnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL_CYCLES, default 1, bubbles per load-use hazard (legal range 1-7).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, MEM_WAIT cycles before timeout is flagged (legal range 1-65535).
REQ-003 SHALL use one clock and a synchronous, active-high reset: ports clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_rs, id_rt  in  ASIZE each  source register addresses of the instruction in ID.
REQ-007 id_uses_rt  in  1  the ID instruction reads rt.
REQ-008 ex_memRead, ex_wen  in  1 each  load / register-write flags of the instruction in EXE.
REQ-009 ex_waddr  in  ASIZE  destination register of the instruction in EXE.
REQ-010 ex_redirect  in  1  taken branch, jump, jal or jr resolved in EXE.
REQ-011 mem_req, mem_ready  in  1 each  MEM-stage data-memory request / completion.
REQ-012 pc_stall, ifid_stall  out  1 each  hold PC and the IF/ID register.
REQ-013 idex_bubble  out  1  load all ID/EXE control fields with 0.
REQ-014 ifid_flush, idex_flush  out  1 each  clear IF/ID and ID/EXE (wrong-path squash).
REQ-015 idex_stall, exmem_stall  out  1 each  hold ID/EXE and EX/MEM.
REQ-016 mem_timeout  out  1  sticky memory-timeout flag.
REQ-017 stall_cnt  out  16  performance counter of stall cycles.
REQ-018 state  out  2  current FSM state (debug).

Function
REQ-019 hazard = ex_memRead & ex_wen & (ex_waddr != 0) & (ex_waddr == id_rs | (id_uses_rt & ex_waddr == id_rt)).
REQ-020 memwait = mem_req & ~mem_ready.
REQ-021 States: RUN=0, LOAD_STALL=1, MEM_WAIT=2; encoding 3 unused and SHALL recover to RUN.
REQ-022 All outputs are combinational from the state register, counters and current inputs; every output other than stall_cnt, mem_timeout and state is 0 unless a rule below asserts it.
REQ-023 Priority in RUN and LOAD_STALL: memwait > ex_redirect > hazard.
REQ-024 Any state with memwait: pc_stall, ifid_stall, idex_stall and exmem_stall = 1; bubble and flushes = 0; ret_state <= the current non-MEM_WAIT state; load-stall counter frozen; next state MEM_WAIT.
REQ-025 RUN with ex_redirect (no memwait): ifid_flush = idex_flush = 1, no stall, remain RUN; a simultaneous hazard is ignored.
REQ-026 RUN with hazard (no memwait, no redirect): pc_stall = ifid_stall = idex_bubble = 1; if LOAD_STALL_CYCLES > 1, lcnt <= LOAD_STALL_CYCLES-1 and next state is LOAD_STALL, else remain RUN.
REQ-027 LOAD_STALL (no memwait): pc_stall = ifid_stall = idex_bubble = 1; lcnt decrements; leave for RUN when lcnt == 1; ex_redirect and hazard are ignored.
REQ-028 MEM_WAIT with mem_ready=0: all four stalls asserted; wcnt increments, saturating at MEM_TIMEOUT; mem_timeout <= 1 when wcnt reaches MEM_TIMEOUT; state remains MEM_WAIT indefinitely.
REQ-029 MEM_WAIT with mem_ready=1: exmem_stall = 0; outputs and next state follow the ret_state rules (REQ-025..027) for this cycle; wcnt <= 0.
REQ-030 stall_cnt increments, saturating at 16'hFFFF, on every cycle with pc_stall = 1.

Reset
REQ-031 While rst=1: state <= RUN, lcnt, wcnt and stall_cnt <= 0, mem_timeout <= 0, ret_state <= RUN; all stall, bubble and flush outputs are forced 0.
REQ-032 Reset asserted mid-stall or mid-MEM_WAIT SHALL abandon that stall; the first cycle after reset evaluates as RUN.

Structure
REQ-033 State encodings and ASIZE SHALL reside in the shared define file.
REQ-034 Hazard comparison (REQ-019) SHALL be a combinational sub-module load_use_detect.

Verification
REQ-035 ex_memRead=1, ex_wen=1, ex_waddr=5, id_rs=5, LOAD_STALL_CYCLES=1 -> one cycle of pc_stall/ifid_stall/idex_bubble, then RUN; stall_cnt=1.
REQ-036 Same stimulus with ex_waddr=0, or id_rt=5 and id_uses_rt=0 -> no stall.
REQ-037 Hazard together with ex_redirect=1 -> ifid_flush=idex_flush=1, pc_stall=0.
REQ-038 LOAD_STALL_CYCLES=3, hazard, then memwait for 4 cycles during the 2nd bubble -> 4 cycles of full stall, then the remaining bubble(s) complete; 3 bubbles total.
REQ-039 MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held for 6 cycles -> mem_timeout=1 from the 5th cycle onward; stays 1 after mem_ready=1 until rst.
REQ-040 rst during LOAD_STALL -> next cycle state=0, all stall/bubble/flush outputs 0, stall_cnt=0.
